// File: rtl/insfetch.sv
// ============================================================================
// Module   : insfetch
// Brief    : Multithreaded instruction fetch stage. Holds one PC per hardware
//            thread, picks one active thread per cycle round-robin, reads
//            instruction memory and registers the word into the fet/dec
//            pipeline register. Handles jump redirect, thread spawn and kill.
// Options  : define FETCH_PERF_EN to add fetch_cnt / bubble_cnt counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module insfetch #(
  parameter int          NUM_TRD  = 8,
  parameter int          TRD_W    = 3,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flushIF,
  input  logic               jmp_en,
  input  logic [TRD_W-1:0]   jmp_trd,
  input  logic [31:0]        jmp_pc,
  input  logic               new_trd_en,
  input  logic [TRD_W-1:0]   new_trd,
  input  logic [31:0]        new_trd_pc,
  input  logic               kill_en,
  input  logic [TRD_W-1:0]   kill_trd,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        ins_dec,
  output logic [TRD_W-1:0]   trd_dec,
  output logic [31:0]        pc_dec,
`ifdef FETCH_PERF_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt,
`endif
  output logic [NUM_TRD-1:0] trd_active
);

  // Architectural state
  logic [31:0]        pc_q [NUM_TRD];
  logic [31:0]        pc_d [NUM_TRD];
  logic [NUM_TRD-1:0] active_q, active_d;
  logic [TRD_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]        ins_dec_q, ins_dec_d;
  logic [TRD_W-1:0]   trd_dec_q, trd_dec_d;
  logic [31:0]        pc_dec_q, pc_dec_d;

  // Selection results
  logic [NUM_TRD-1:0] kill_mask;
  logic [NUM_TRD-1:0] cand;
  logic               sel_found;
  logic [TRD_W-1:0]   sel_idx;
  logic [TRD_W-1:0]   scan_idx;
  logic               issue;

  // Round-robin scan starting just after the last issued thread; a thread
  // being killed this cycle is not eligible.
  always_comb begin
    kill_mask = '0;
    if (kill_en) kill_mask[kill_trd] = 1'b1;
    cand      = active_q & ~kill_mask;
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_TRD; i++) begin
      scan_idx = rr_ptr_q + TRD_W'(i);
      if (!sel_found && cand[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign imem_addr = sel_found ? pc_q[sel_idx] : 32'h0;
  assign issue     = !stall && !flushIF && sel_found;

  // Next-state for the pipeline register, round-robin pointer and per-thread
  // PC/active bits. Per thread: kill beats jump beats spawn beats increment.
  always_comb begin
    ins_dec_d = ins_dec_q;
    trd_dec_d = trd_dec_q;
    pc_dec_d  = pc_dec_q;
    rr_ptr_d  = rr_ptr_q;
    pc_d      = pc_q;
    active_d  = active_q;

    if (!stall) begin
      if (issue) begin
        ins_dec_d = imem_data;
        trd_dec_d = sel_idx;
        pc_dec_d  = pc_q[sel_idx];
        rr_ptr_d  = sel_idx;
      end else begin
        ins_dec_d = '0;
        trd_dec_d = '0;
        pc_dec_d  = '0;
      end
    end

    for (int t = 0; t < NUM_TRD; t++) begin
      if (kill_en && kill_trd == TRD_W'(t)) begin
        active_d[t] = 1'b0;
      end else if (jmp_en && jmp_trd == TRD_W'(t)) begin
        // Jump does not activate a sleeping thread, and it wins over the
        // increment of a thread that is fetching this very cycle.
        pc_d[t] = jmp_pc;
      end else if (new_trd_en && new_trd == TRD_W'(t)) begin
        pc_d[t]     = new_trd_pc;
        active_d[t] = 1'b1;
      end else if (issue && sel_idx == TRD_W'(t)) begin
        pc_d[t] = pc_q[t] + PC_INC;
      end
    end
  end

  // State registers; reset leaves only thread 0 running from RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TRD; t++) begin
        pc_q[t] <= (t == 0) ? RESET_PC : 32'h0;
      end
      active_q  <= NUM_TRD'(1);
      rr_ptr_q  <= TRD_W'(NUM_TRD - 1);
      ins_dec_q <= '0;
      trd_dec_q <= '0;
      pc_dec_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      active_q  <= active_d;
      rr_ptr_q  <= rr_ptr_d;
      ins_dec_q <= ins_dec_d;
      trd_dec_q <= trd_dec_d;
      pc_dec_q  <= pc_dec_d;
    end
  end

  assign ins_dec    = ins_dec_q;
  assign trd_dec    = trd_dec_q;
  assign pc_dec     = pc_dec_q;
  assign trd_active = active_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Issue and bubble counters; stalled cycles count as neither.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (!stall) begin
      if (issue) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      else       bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_insfetch.sv
// ============================================================================
// Module   : tb_insfetch
// Brief    : Directed self-checking bench for insfetch. Expected fet/dec
//            contents are queued when a cycle is driven and compared after
//            the edge. Instruction memory returns addr | 0xA000_0000.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_insfetch;

  localparam int NUM_TRD = 8;
  localparam int TRD_W   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall, flushIF;
  logic               jmp_en;
  logic [TRD_W-1:0]   jmp_trd;
  logic [31:0]        jmp_pc;
  logic               new_trd_en;
  logic [TRD_W-1:0]   new_trd;
  logic [31:0]        new_trd_pc;
  logic               kill_en;
  logic [TRD_W-1:0]   kill_trd;
  logic [31:0]        imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        ins_dec;
  logic [TRD_W-1:0]   trd_dec;
  logic [31:0]        pc_dec;
  logic [NUM_TRD-1:0] trd_active;
`ifdef FETCH_PERF_EN
  logic [31:0]        fetch_cnt, bubble_cnt;
`endif

  typedef struct {
    logic [31:0] ins;
    logic [31:0] trd;
    logic [31:0] pc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  assign imem_data = imem_addr | 32'hA000_0000;

  always #5 clk = ~clk;

  insfetch dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flushIF    (flushIF),
    .jmp_en     (jmp_en),
    .jmp_trd    (jmp_trd),
    .jmp_pc     (jmp_pc),
    .new_trd_en (new_trd_en),
    .new_trd    (new_trd),
    .new_trd_pc (new_trd_pc),
    .kill_en    (kill_en),
    .kill_trd   (kill_trd),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .ins_dec    (ins_dec),
    .trd_dec    (trd_dec),
    .pc_dec     (pc_dec),
`ifdef FETCH_PERF_EN
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .trd_active (trd_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctrl();
    stall = 0; flushIF = 0;
    jmp_en = 0; jmp_trd = '0; jmp_pc = '0;
    new_trd_en = 0; new_trd = '0; new_trd_pc = '0;
    kill_en = 0; kill_trd = '0;
  endtask

  // Queue the expected register contents, clock once, pop and compare.
  task automatic step(input string tag, input logic [31:0] e_ins,
                      input logic [31:0] e_trd, input logic [31:0] e_pc);
    exp_t e;
    e.ins = e_ins; e.trd = e_trd; e.pc = e_pc; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    clear_ctrl();
    e = sb.pop_front();
    check({e.tag, ".ins"}, ins_dec, e.ins);
    check({e.tag, ".trd"}, 32'(trd_dec), e.trd);
    check({e.tag, ".pc"},  pc_dec, e.pc);
  endtask

  initial begin
    clear_ctrl();
    rst = 1;
    #12;
    check("rst.ins", ins_dec, 32'h0);
    check("rst.trd", 32'(trd_dec), 32'h0);
    check("rst.pc", pc_dec, 32'h0);
    check("rst.active", 32'(trd_active), 32'h1);
    check("rst.addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;   // first fetch edge after release
    check("t0.f0.ins", ins_dec, 32'hA000_0000);
    check("t0.f0.pc", pc_dec, 32'h0);

    // Single thread streaming
    step("t0.f1", 32'hA000_0004, 0, 32'h4);
    step("t0.f2", 32'hA000_0008, 0, 32'h8);

    // Spawn t3 while t0 runs; t3 is not eligible until the next cycle
    new_trd_en = 1; new_trd = 3; new_trd_pc = 32'h100;
    step("spawn.t0", 32'hA000_000C, 0, 32'hC);
    check("spawn.active", 32'(trd_active), 32'h9);
    step("rr.t3a", 32'hA000_0100, 3, 32'h100);
    step("rr.t0a", 32'hA000_0010, 0, 32'h10);
    step("rr.t3b", 32'hA000_0104, 3, 32'h104);
    step("rr.t0b", 32'hA000_0014, 0, 32'h14);

    // Kill t3: it is excluded from this cycle's scan, t0 fetches
    kill_en = 1; kill_trd = 3;
    step("kill3", 32'hA000_0018, 0, 32'h18);
    // Kill the only active thread: nothing selectable
    kill_en = 1; kill_trd = 0;
    #1 check("kill0.addr", imem_addr, 32'h0);
    step("kill0", 0, 0, 0);
    check("kill0.active", 32'(trd_active), 32'h0);
    step("idle.bub", 0, 0, 0);
    new_trd_en = 1; new_trd = 5; new_trd_pc = 32'h40;
    step("spawn5.bub", 0, 0, 0);
    step("t5.f0", 32'hA000_0040, 5, 32'h40);

    // Kill t5 and respawn t0 in the same cycle
    kill_en = 1; kill_trd = 5;
    new_trd_en = 1; new_trd = 0; new_trd_pc = 32'h80;
    step("swap.bub", 0, 0, 0);
    check("swap.active", 32'(trd_active), 32'h1);
    step("t0.f80", 32'hA000_0080, 0, 32'h80);

    // Stall holds everything; stall beats flushIF; jump lands under stall
    stall = 1; flushIF = 1;
    #1 check("stall1.addr", imem_addr, 32'h84);
    step("stall1", 32'hA000_0080, 0, 32'h80);
    stall = 1;
    #1 check("stall2.addr", imem_addr, 32'h84);
    step("stall2", 32'hA000_0080, 0, 32'h80);
    stall = 1; jmp_en = 1; jmp_trd = 0; jmp_pc = 32'h200;
    step("stall3.jmp", 32'hA000_0080, 0, 32'h80);
    step("after.stall", 32'hA000_0200, 0, 32'h200);

    // flushIF with a same-cycle jump
    flushIF = 1; jmp_en = 1; jmp_trd = 0; jmp_pc = 32'h300;
    step("flush.jmp", 0, 0, 0);
    step("after.flush", 32'hA000_0300, 0, 32'h300);

    // Jump to the thread being fetched: word still issued, increment dropped
    jmp_en = 1; jmp_trd = 0; jmp_pc = 32'h400;
    step("jmp.sel", 32'hA000_0304, 0, 32'h304);
    step("jmp.tgt", 32'hA000_0400, 0, 32'h400);

    // PC wrap at 2^32
    jmp_en = 1; jmp_trd = 0; jmp_pc = 32'hFFFF_FFFC;
    step("wrap.jmp", 32'hA000_0404, 0, 32'h404);
    step("wrap.top", 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    step("wrap.zero", 32'hA000_0000, 0, 32'h0);

    // Asynchronous reset mid-cycle
    #2 rst = 1;
    #1;
    check("arst.ins", ins_dec, 32'h0);
    check("arst.trd", 32'(trd_dec), 32'h0);
    check("arst.pc", pc_dec, 32'h0);
    check("arst.active", 32'(trd_active), 32'h1);
    check("arst.addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
